pipe_stage_reg: RTL

Parametrised pipeline stage register for the MIPS-lite datapath, the generalised replacement for the fixed per-stage latches (IF/ID, ID/EX, EX/MEM, MEM/WB). Carries a control vector and a data payload between stages with a valid/ready handshake, synchronous flush (bubble insertion) and a saturating stall counter. An optional skid buffer makes `in_ready` a pure register output.

---
 rtl/pipe_pkg.sv | 20 ++
 rtl/pipe_skid_buf.sv | 37 +++
 rtl/pipe_stage_reg.sv | 106 ++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for the MIPS-lite pipeline stage registers.
// Default widths, control-vector bit positions and the bubble encoding.
package pipe_pkg;

  localparam int CTRL_W_DEF = 6;
  localparam int DATA_W_DEF = 102;
  localparam int CNT_W_DEF  = 16;

  localparam int CTRL_REGWRITE = 5;
  localparam int CTRL_MEMTOREG = 4;
  localparam int CTRL_MEMREAD  = 3;
  localparam int CTRL_MEMWRITE = 2;
  localparam int CTRL_BRANCH   = 1;
  localparam int CTRL_JR       = 0;

  typedef logic [CTRL_W_DEF-1:0] ctrl_t;

  localparam ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/pipe_skid_buf.sv
// One-entry skid register with valid flag, used by pipe_stage_reg when
// PIPE_STAGE_SKID_EN is defined. clr wins over load/drain.
module pipe_skid_buf #(
  parameter int CTRL_W = 6,
  parameter int DATA_W = 102
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              load,
  input  logic              drain,
  input  logic [CTRL_W-1:0] load_ctrl,
  input  logic [DATA_W-1:0] load_data,
  output logic              valid,
  output logic [CTRL_W-1:0] ctrl,
  output logic [DATA_W-1:0] data
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
      ctrl  <= '0;
      data  <= '0;
    end else if (clr) begin
      valid <= 1'b0;
      ctrl  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      ctrl  <= load_ctrl;
      data  <= load_data;
    end else if (drain) begin
      valid <= 1'b0;
      ctrl  <= '0;
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register: control + payload with valid/ready, flush and
// saturating stall counter. Define PIPE_STAGE_SKID_EN for a registered in_ready.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int CTRL_W = CTRL_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  stall_cnt
);

  logic              xfer_in;
  logic              xfer_out;
  logic              skid_valid;
  logic [CTRL_W-1:0] skid_ctrl;
  logic [DATA_W-1:0] skid_data;
  logic              main_load;
  logic [CTRL_W-1:0] main_ctrl_nxt;
  logic [DATA_W-1:0] main_data_nxt;

  assign xfer_in  = in_valid && in_ready;
  assign xfer_out = out_valid && out_ready;

`ifdef PIPE_STAGE_SKID_EN
  logic skid_load;
  logic skid_drain;

  assign in_ready   = !skid_valid;
  // A beat arriving while main is full and blocked parks in the skid entry.
  assign skid_load  = !flush && xfer_in && out_valid && !out_ready;
  assign skid_drain = !flush && xfer_out && skid_valid;

  pipe_skid_buf #(
    .CTRL_W (CTRL_W),
    .DATA_W (DATA_W)
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .clr       (flush),
    .load      (skid_load),
    .drain     (skid_drain),
    .load_ctrl (in_ctrl),
    .load_data (in_data),
    .valid     (skid_valid),
    .ctrl      (skid_ctrl),
    .data      (skid_data)
  );
`else
  assign in_ready   = !out_valid || out_ready || flush;
  assign skid_valid = 1'b0;
  assign skid_ctrl  = CTRL_W'(CTRL_BUBBLE);
  assign skid_data  = '0;
`endif

  always_comb begin
    main_load     = 1'b0;
    main_ctrl_nxt = in_ctrl;
    main_data_nxt = in_data;
    if (xfer_out && skid_valid) begin
      main_load     = 1'b1;
      main_ctrl_nxt = skid_ctrl;
      main_data_nxt = skid_data;
    end else if (xfer_in && (!out_valid || out_ready)) begin
      main_load = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_ctrl  <= '0;
      out_data  <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
      out_ctrl  <= '0;
    end else if (main_load) begin
      out_valid <= 1'b1;
      out_ctrl  <= main_ctrl_nxt;
      out_data  <= main_data_nxt;
    end else if (xfer_out) begin
      out_valid <= 1'b0;
      out_ctrl  <= '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (out_valid && !out_ready && !flush && (stall_cnt != {CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule
